// File: rtl/rv_divide.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It stalls the execute stage from the start cycle until the registered result is ready.
module rv_divide (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_valid_i,
    input  logic        d_is_divide_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [2:0]  d_fun_i,
    output logic        x_stall_req_o,
    output logic [31:0] x_rd_o
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

    typedef struct packed {
        logic sgn;
        logic rem_sel;
        logic q_neg;
        logic r_neg;
    } div_op_t;

    state_t      state;
    div_op_t     op;
    logic [31:0] dvd;   // dividend, becomes the quotient as bits shift in
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [5:0]  cnt;

    logic        start;
    logic        d_signed;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        ge;
    logic [31:0] rs1_orig;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign start    = d_valid_i & d_is_divide_i & ~x_kill_i & (state == IDLE);
    assign d_signed = ~d_fun_i[0];

    assign x_stall_req_o = ~x_kill_i &
                           (start | (state == LOAD) | (state == ITER) | (state == FIX));

    // No borrow out of the 33-bit subtract means the shifted remainder covers the divisor
    assign rem_sh   = {rem, dvd[31]};
    assign rem_diff = rem_sh - {1'b0, dvs};
    assign ge       = ~rem_diff[32];

    // Only the magnitude of rs1 is kept; r_neg is exactly rs1's sign for signed ops
    assign rs1_orig = op.r_neg ? -dvd : dvd;
    assign q_fix    = op.q_neg ? -dvd : dvd;
    assign r_fix    = op.r_neg ? -rem : rem;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            op     <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            x_rd_o <= '0;
        end else if (x_kill_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op.sgn     <= d_signed;
                        op.rem_sel <= d_fun_i[1];
                        op.q_neg   <= d_signed & (d_rs1_i[31] ^ d_rs2_i[31]);
                        op.r_neg   <= d_signed & d_rs1_i[31];
                        dvd        <= (d_signed & d_rs1_i[31]) ? -d_rs1_i : d_rs1_i;
                        dvs        <= (d_signed & d_rs2_i[31]) ? -d_rs2_i : d_rs2_i;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (dvs == 32'd0) begin
                        x_rd_o <= op.rem_sel ? rs1_orig : 32'hFFFF_FFFF;
                        state  <= DONE;
                    end else if (op.sgn & op.r_neg & ~op.q_neg &
                                 (dvd == 32'h8000_0000) & (dvs == 32'd1)) begin
                        // -2^31 / -1: both operands negative, divisor magnitude 1
                        x_rd_o <= op.rem_sel ? 32'd0 : 32'h8000_0000;
                        state  <= DONE;
                    end else begin
                        rem   <= '0;
                        cnt   <= 6'd31;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem <= ge ? rem_diff[31:0] : rem_sh[31:0];
                    dvd <= {dvd[30:0], ge};
                    if (cnt == 6'd0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                FIX: begin
                    x_rd_o <= op.rem_sel ? r_fix : q_fix;
                    state  <= DONE;
                end
                DONE: begin
                    if (!x_stall_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_divide.sv
// Scoreboarded bench for rv_divide: stimulus pushes expected result and stall length,
// a negedge monitor pops and compares when the stall request falls.
module tb_rv_divide;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        x_kill_i = 1'b0;
    logic        d_valid_i = 1'b0;
    logic        d_is_divide_i = 1'b0;
    logic [31:0] d_rs1_i = '0;
    logic [31:0] d_rs2_i = '0;
    logic [2:0]  d_fun_i = '0;
    logic        tb_hold = 1'b0;
    logic        x_stall_req_o;
    logic [31:0] x_rd_o;
    wire         x_stall_i = x_stall_req_o | tb_hold;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    rv_divide dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .x_stall_i     (x_stall_i),
        .x_kill_i      (x_kill_i),
        .d_valid_i     (d_valid_i),
        .d_is_divide_i (d_is_divide_i),
        .d_rs1_i       (d_rs1_i),
        .d_rs2_i       (d_rs2_i),
        .d_fun_i       (d_fun_i),
        .x_stall_req_o (x_stall_req_o),
        .x_rd_o        (x_rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: counts stall-high cycles per op and scores the result when stall drops
    int hi_cnt = 0;
    bit prev_hi = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i || x_kill_i) begin
            hi_cnt  = 0;
            prev_hi = 1'b0;
        end else if (x_stall_req_o) begin
            hi_cnt++;
            prev_hi = 1'b1;
        end else if (prev_hi) begin
            prev_hi = 1'b0;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got %h with nothing pending", x_rd_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_val"}, x_rd_o, e.val);
                check({e.name, "_lat"}, 32'(hi_cnt), 32'(e.cyc));
            end
            hi_cnt = 0;
        end
    end

    // Issue one divide at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again
    task automatic run_div(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int cyc, input string name,
                           input int hold);
        bit done;
        exp_t e;
        e.val = exp; e.cyc = cyc; e.name = name;
        sb.push_back(e);
        d_valid_i = 1'b1; d_is_divide_i = 1'b1;
        d_fun_i = fun; d_rs1_i = a; d_rs2_i = b;
        tb_hold = (hold > 0);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i); #1;
            if (!x_stall_req_o) begin done = 1'b1; break; end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: stall_req still high after 100 cycles, expected to drop", name);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check({name, "_hold_rd"}, x_rd_o, exp);
            check({name, "_hold_norestart"}, {31'd0, x_stall_req_o}, 32'd0);
        end
        tb_hold = 1'b0;
        @(posedge clk_i); #1;
        d_valid_i = 1'b0; d_is_divide_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check("reset_rd", x_rd_o, 32'd0);
        check("reset_stall", {31'd0, x_stall_req_o}, 32'd0);
        @(posedge clk_i); #1;

        run_div(F_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 35, "div_100_m7",  0);
        run_div(F_REM,  32'd100,        32'hFFFF_FFF9, 32'd2,         35, "rem_100_m7",  0);
        run_div(F_DIVU, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, 35, "divu_max_16", 0);
        run_div(F_REMU, 32'hFFFF_FFFF,  32'd16,        32'd15,        35, "remu_max_16", 0);
        run_div(F_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35, "div_m7_2",    0);
        run_div(F_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35, "rem_m7_2",    0);
        run_div(F_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 2,  "div_5_0",     0);
        run_div(F_REMU, 32'd5,          32'd0,         32'd5,         2,  "remu_5_0",    0);
        run_div(F_REM,  32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 2,  "rem_m7_0",    0);
        run_div(F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  "div_ovf",     0);
        run_div(F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,  "rem_ovf",     0);
        run_div(F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         35, "divu_ovf",    0);
        run_div(F_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 35, "remu_ovf",    0);
        run_div(F_DIV,  32'h8000_0000,  32'd2,         32'hC000_0000, 35, "div_min_2",   0);
        run_div(F_DIVU, 32'h8000_0000,  32'd1,         32'h8000_0000, 35, "divu_min_1",  0);

        // Kill a divide partway through ITER
        d_valid_i = 1'b1; d_is_divide_i = 1'b1;
        d_fun_i = F_DIV; d_rs1_i = 32'd1000; d_rs2_i = 32'd3;
        repeat (12) begin @(posedge clk_i); #1; end
        check("kill_busy", {31'd0, x_stall_req_o}, 32'd1);
        x_kill_i = 1'b1;
        #1;
        check("kill_stall_low", {31'd0, x_stall_req_o}, 32'd0);
        check("kill_rd_held", x_rd_o, 32'h8000_0000);
        @(posedge clk_i); #1;
        x_kill_i = 1'b0; d_valid_i = 1'b0; d_is_divide_i = 1'b0;
        #1;
        check("kill_idle", {31'd0, x_stall_req_o}, 32'd0);
        @(posedge clk_i); #1;

        // Clean restart after kill, with the pipeline held in DONE for 3 cycles
        run_div(F_DIV, 32'd1000, 32'd3, 32'd333, 35, "div_after_kill", 3);

        // Reset mid-ITER
        d_valid_i = 1'b1; d_is_divide_i = 1'b1;
        d_fun_i = F_DIVU; d_rs1_i = 32'hFFFF_FFFF; d_rs2_i = 32'd16;
        repeat (15) begin @(posedge clk_i); #1; end
        rst_i = 1'b1; d_valid_i = 1'b0; d_is_divide_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        check("midreset_rd", x_rd_o, 32'd0);
        check("midreset_stall", {31'd0, x_stall_req_o}, 32'd0);
        @(posedge clk_i); #1;

        run_div(F_REM, 32'd1000, 32'hFFFF_FFFD, 32'd1, 35, "rem_after_reset", 0);

        repeat (5) @(posedge clk_i);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s_missing: no result seen, expected %h", e.name, e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_divide.md
Name: rv_divide

Overview:
- Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the execute stage as the companion of the single-cycle-issue multiplier.
- Takes the same decode-stage operands (d_rs1_i, d_rs2_i, d_fun_i) and holds the pipeline via a stall request until its result is ready.
- Its registered result feeds the writeback result mux.

Parameters:
- None.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous reset, active-high.
- x_stall_i  input  1  pipeline stall (includes this block's own request); the execute stage advances only when low.
- x_kill_i  input  1  flush of the instruction in decode/execute; aborts any divide in progress.
- d_valid_i  input  1  decode stage holds a valid instruction.
- d_is_divide_i  input  1  decoded instruction is a DIV/DIVU/REM/REMU.
- d_rs1_i  input  32  dividend.
- d_rs2_i  input  32  divisor.
- d_fun_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- x_stall_req_o  output  1  divider busy; pipeline must stall.
- x_rd_o  output  32  result (quotient or remainder), registered.

Behaviour:
- Reset state:
  - State IDLE, x_rd_o=0, x_stall_req_o=0.
  - All internal registers cleared.
  - Reset mid-divide abandons the operation.
- start = d_valid_i & d_is_divide_i & !x_kill_i & (state==IDLE).
- x_stall_req_o is combinational: high when start, or when state is LOAD, ITER or FIX. It is low in IDLE (without start) and in DONE.
- State machine:
  - IDLE: on start, latch the operands, with inputs sampled at this edge.
    - signed = !d_fun_i[0]; rem_sel = d_fun_i[1].
    - Latch |rs1| and |rs2| when signed, raw values otherwise.
    - q_neg = signed & (rs1[31]^rs2[31]); r_neg = signed & rs1[31].
    - Go to LOAD.
  - LOAD: detect special cases and set the result directly, going to DONE.
    - Divide by zero (rs2==0): quotient=32'hFFFFFFFF, remainder=original rs1.
    - Signed overflow (rs1==32'h80000000, rs2==32'hFFFFFFFF, signed): quotient=32'h80000000, remainder=0.
    - Otherwise clear remainder, load the 6-bit counter with 31, go to ITER.
  - ITER: one quotient bit per cycle.
    - Shift {rem,dividend} left by 1.
    - If rem_shifted >= divisor, then rem -= divisor and q bit=1.
    - When counter==0, go to FIX; else decrement. Exactly 32 ITER cycles.
  - FIX: negate the quotient if q_neg and the remainder if r_neg (two's complement, modulo 2^32).
    - x_rd_o <= rem_sel ? remainder : quotient.
    - Go to DONE.
  - DONE: x_stall_req_o low, x_rd_o stable.
    - If !x_stall_i, go to IDLE; the instruction retires on this edge.
    - Otherwise hold in DONE. No restart from DONE, even though d_* still presents the same divide.
- Latency (start edge = cycle 0): normal divide has x_rd_o valid and stall_req low from cycle 35 (LOAD 1, ITER 32, FIX 1); special cases from cycle 2.
- x_kill_i high in any state: next state IDLE and x_stall_req_o low in the same cycle. x_rd_o holds its old value.
- x_rd_o changes only in LOAD (special case), FIX, or reset.
- Unsigned ops ignore sign bits entirely. 32'h80000000 DIVU 1 = 32'h80000000.
- Back-to-back divides: the second start occurs in the cycle after DONE→IDLE, never overlapped with the first.

Test Plan:
- DIV 100 by -7 (rs2=32'hFFFFFFF9): stall_req high 35 cycles → x_rd_o=32'hFFFFFFF2 (-14); REM same operands → 2.
- DIVU 32'hFFFFFFFF by 16 → 32'h0FFFFFFF; REMU → 15.
- DIV -7 by 2 → -3; REM → -1 (remainder takes the dividend's sign).
- Divide by zero: DIV 5/0 → 32'hFFFFFFFF; REMU 5/0 → 5; stall_req high only cycles 0–1.
- Overflow: DIV 32'h80000000 by -1 → 32'h80000000; REM → 0; DIVU same operands → 0 after the full 35 cycles.
- Kill and hold:
  - x_kill_i at ITER cycle 10 → stall_req low the same cycle, state IDLE, the next divide starts cleanly and is correct.
  - x_stall_i held high 3 cycles in DONE → x_rd_o stable, no restart.
  - Reset pulse mid-ITER → outputs 0, IDLE.
